// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer.
//   - ALU select codes understood by the external combinational ALU
//   - sequencer FSM state encoding
//   - issue_sel(): maps a requested op onto the code actually issued in EXEC
package alu_defs;

    localparam logic [3:0] ALU_HOLD = 4'b0000;  // never issued: the ALU infers a latch on it
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_NOT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SHL1 = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    // HOLD becomes PASS; a zero-length shift degenerates to PASS as well.
    // Every other code (including undefined ones) is issued unchanged.
    function automatic logic [3:0] issue_sel(input logic [3:0] op, input logic shamt_zero);
        if (op == ALU_HOLD || (op == ALU_SHL1 && shamt_zero))
            return ALU_PASS;
        return op;
    endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> requester 0)
//   req_i      : request vector
//   advance_i  : a grant was consumed this cycle; rotate past the granted index
//   grant_o    : one-hot grant (zero when no request)
//   idx_o      : encoded index of grant_o
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    // Scan NREQ positions starting at the pointer; first live request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    // Next search starts just after the index that was served.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i)
            ptr_d = (idx_o == IW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one combinational 32-bit ALU between NREQ requesters.
// A round-robin arbiter picks a requester in IDLE; the command is latched and
// either issued once (EXEC) or, for shift-left-by-N, run as N shift-by-1
// passes through the ALU (SHIFT). The result is held in RESP until taken.
//   req_valid/req_ready          : per-requester handshake (ready is one-hot or 0)
//   req_op/req_a/req_b/req_shamt : packed per-requester command fields
//   alu_a/alu_b/alu_sel          : driven to the ALU from registered state only
//   alu_result                   : combinational ALU output
//   rsp_valid/rsp_ready          : result handshake; rsp_id/rsp_data stable while valid
import alu_defs::*;

module alu_sequencer #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int SHW  = 5,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_op,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*SHW-1:0] req_shamt,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_sel,
    input  logic [W-1:0]      alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_data
);

    seq_state_t     state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]  id_q, id_d;
    logic [W-1:0]   rsp_q, rsp_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            xfer;
    logic [3:0]      op_g;
    logic [W-1:0]    a_g, b_g;
    logic [SHW-1:0]  sh_g;

    // Grant is only ever set on a valid request, so any valid in IDLE transfers.
    assign xfer = (state_q == ST_IDLE) && (|req_valid);

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .advance_i (xfer),
        .grant_o   (grant),
        .idx_o     (gidx)
    );

    assign op_g = req_op[int'(gidx)*4 +: 4];
    assign a_g  = req_a[int'(gidx)*W +: W];
    assign b_g  = req_b[int'(gidx)*W +: W];
    assign sh_g = req_shamt[int'(gidx)*SHW +: SHW];

    assign rsp_id   = id_q;
    assign rsp_data = rsp_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        rsp_d     = rsp_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = ALU_PASS;

        case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (xfer) begin
                    op_d    = issue_sel(op_g, sh_g == '0);
                    a_d     = a_g;
                    b_d     = b_g;
                    acc_d   = a_g;
                    cnt_d   = sh_g;
                    id_d    = gidx;
                    state_d = (op_g == ALU_SHL1 && sh_g != '0) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_sel = op_q;
                rsp_d   = alu_result;
                state_d = ST_RESP;
            end
            ST_SHIFT: begin
                // One bit per cycle through the ALU; overflow bits fall off the top.
                alu_a   = acc_q;
                alu_sel = ALU_SHL1;
                acc_d   = alu_result;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    rsp_d   = alu_result;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= ALU_PASS;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the 32-bit ALU.
module tb_alu_sequencer;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int SHW  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*4-1:0] req_op = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ*SHW-1:0] req_shamt = '0;
    logic [W-1:0]      alu_a, alu_b, alu_result;
    logic [3:0]        alu_sel;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [0:0]        rsp_id;
    logic [W-1:0]      rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.NREQ(NREQ), .W(W), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    // ALU model; undefined codes behave as ADD.
    always_comb begin
        case (alu_sel)
            4'b0001: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b0101: alu_result = alu_a & alu_b;
            4'b0110: alu_result = alu_a | alu_b;
            4'b0111: alu_result = ~alu_a;
            4'b1000: alu_result = alu_a ^ alu_b;
            4'b1001: alu_result = alu_a << 1;
            4'b1011: alu_result = alu_a;
            default: alu_result = alu_a + alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The hold code must never reach the ALU.
    always @(negedge clk) if (!rst) check("sel_not_hold", 32'(alu_sel == 4'b0000), 32'd0);

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        req_valid[i]         = v;
        req_op[i*4 +: 4]     = op;
        req_a[i*W +: W]      = a;
        req_b[i*W +: W]      = b;
        req_shamt[i*SHW +: SHW] = sh;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    // One command from requester i starting in IDLE; checks grant, issue, latency, result.
    task automatic run_single(input string tag, input int i, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                              input logic [3:0] exp_sel, input logic [31:0] exp, input int lat);
        int n;
        req_valid = '0;
        set_req(i, 1'b1, op, a, b, sh);
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 32'(1 << i));
        tick;
        req_valid = '0;
        check({tag, "_sel"}, 32'(alu_sel), 32'(exp_sel));
        check({tag, "_alu_a"}, alu_a, a);
        n = 1;
        while (!rsp_valid && n < 200) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_id"}, 32'(rsp_id), 32'(i));
        tick;
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset values
        tick;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'hB);
        rst = 1'b0;
        tick;

        // 1. ADD 5+7 on req0, response at T+2
        run_single("add", 0, 4'b0001, 32'd5, 32'd7, 5'd0, 4'b0001, 32'd12, 2);

        // 2. Both requesters continuously valid from reset: grants 0, 1, 0
        do_reset;
        set_req(0, 1'b1, 4'b0010, 32'd10, 32'd3, 5'd0);
        set_req(1, 1'b1, 4'b0010, 32'd10, 32'd3, 5'd0);
        #1;
        check("rr_first", 32'(req_ready), 32'b01);
        tick;
        check("rr_busy", 32'(req_ready), 32'b00);
        tick;
        check("rr_first_id", 32'(rsp_id), 32'd0);
        check("rr_first_data", rsp_data, 32'd7);
        tick;
        check("rr_second", 32'(req_ready), 32'b10);
        tick; tick;
        check("rr_second_id", 32'(rsp_id), 32'd1);
        check("rr_second_data", rsp_data, 32'd7);
        tick;
        check("rr_third", 32'(req_ready), 32'b01);
        req_valid = '0;
        tick;

        // 3. Shifts: full-width, zero-length, and overflow loss
        run_single("shl31", 0, 4'b1001, 32'h0000_0001, 32'd0, 5'd31, 4'b1001, 32'h8000_0000, 32);
        run_single("shl0", 1, 4'b1001, 32'h0000_0001, 32'd0, 5'd0, 4'b1011, 32'h0000_0001, 2);
        run_single("shl3", 0, 4'b1001, 32'hF000_0001, 32'd0, 5'd3, 4'b1001, 32'h8000_0008, 4);

        // 4. Backpressure: response held for 5 cycles, then next grant
        req_valid = '0;
        set_req(1, 1'b1, 4'b1000, 32'h0000_FF00, 32'h0000_0F0F, 5'd0);
        #1;
        check("bp_rdy", 32'(req_ready), 32'b10);
        tick;
        req_valid = '0;
        set_req(0, 1'b1, 4'b0001, 32'd1, 32'd1, 5'd0);
        rsp_ready = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", rsp_data, 32'h0000_F00F);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        check("bp_next", 32'(req_ready), 32'b01);
        tick;
        req_valid = '0;
        tick;
        check("bp_next_data", rsp_data, 32'd2);
        check("bp_next_id", 32'(rsp_id), 32'd0);
        tick;

        // 5. HOLD remapped to PASS; undefined code executes as ADD
        run_single("hold", 0, 4'b0000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 4'b1011, 32'hDEAD_BEEF, 2);
        run_single("undef", 1, 4'b0011, 32'd1, 32'd2, 5'd0, 4'b0011, 32'd3, 2);

        // 6. Reset during shift cycle 8 of a 20-cycle shift
        req_valid = '0;
        set_req(0, 1'b1, 4'b1001, 32'd1, 32'd0, 5'd20);
        tick;
        req_valid = '0;
        for (int k = 0; k < 7; k++) tick;
        check("abort_in_shift", 32'(alu_sel), 32'b1001);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_data", rsp_data, 32'd0);
        check("abort_id", 32'(rsp_id), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_alu_a", alu_a, 32'd0);
        check("abort_alu_b", alu_b, 32'd0);
        check("abort_alu_sel", 32'(alu_sel), 32'hB);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_single("after_abort", 1, 4'b0001, 32'd2, 32'd3, 5'd0, 4'b0001, 32'd5, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
